cfa_window_gen: RTL

CFA_WINDOW_GEN -- requirements
Module: cfa_window_gen

---
 rtl/cfa_pkg.sv | 26 ++
 rtl/cfa_line_buffer.sv | 32 +++
 rtl/cfa_window_gen.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA window generator.
//   cfa_state_t : controller state encoding
//   bayer_t     : colour codes carried alongside every raw sample
//   CFA_*       : default widths/depths used as parameter defaults
package cfa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cfa_state_t;

  typedef enum logic [1:0] {
    BAYER_R  = 2'd0,
    BAYER_GR = 2'd1,
    BAYER_GB = 2'd2,
    BAYER_B  = 2'd3
  } bayer_t;

  localparam int CFA_PIXEL_W     = 8;
  localparam int CFA_ROW_W       = 11;
  localparam int CFA_COL_W       = 11;
  localparam int CFA_FILTER_SIZE = 5;
  localparam int CFA_LINE_DEPTH  = 2048;

endpackage

// File: rtl/cfa_line_buffer.sv
// One image line of delay for {symbol, pixel}.
// Ports:
//   clk     rising-edge clock
//   en      write din and update dout this cycle (one accepted pixel)
//   wr_addr write address
//   rd_addr read address, registered into dout when en is high
//   din     sample to store
//   dout    registered read data (holds while en is low)
// Memory contents are never reset.
module cfa_line_buffer #(
  parameter int depth     = 2048,
  parameter int width     = 10,
  parameter int addrWidth = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [addrWidth-1:0] wr_addr,
  input  logic [addrWidth-1:0] rd_addr,
  input  logic [width-1:0]     din,
  output logic [width-1:0]     dout
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[wr_addr] <= din;
      dout         <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/cfa_window_gen.sv
// Raster-order CFA sample stream -> 5x5 neighbourhood windows.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   IDLE    | waiting for start; pixels ignored; ready high
//   RUN     | accepting pixels, advancing row/col counters
//   DONE    | one cycle after the last pixel; done pulses here
//
// Ports:
//   clk, rst             clock, async active-high reset
//   start                one-cycle pulse, begins (or restarts) a frame
//   rowMax, colMax       inclusive frame limits, captured on start
//   pixelIn, bayerSymbolIn, pixelValid   input sample stream
//   ready                high in IDLE
//   window               5x5 taps, tap (r,c) at [(r*5+c)*pixelBitWidth +: pixelBitWidth]
//   centerSymbol         colour code of tap (2,2)
//   windowValid          window/centre outputs valid this cycle
//   centerRow, centerCol image coordinates of tap (2,2)
//   done                 one-cycle frame-end pulse
module cfa_window_gen
  import cfa_pkg::*;
#(
  parameter int pixelBitWidth = CFA_PIXEL_W,
  parameter int rowBitWidth   = CFA_ROW_W,
  parameter int colBitWidth   = CFA_COL_W,
  parameter int filterSize    = CFA_FILTER_SIZE,
  parameter int lineDepth     = CFA_LINE_DEPTH
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [rowBitWidth-1:0]                         rowMax,
  input  logic [colBitWidth-1:0]                         colMax,
  input  logic [pixelBitWidth-1:0]                       pixelIn,
  input  logic [1:0]                                     bayerSymbolIn,
  input  logic                                           pixelValid,
  output logic                                           ready,
  output logic [filterSize*filterSize*pixelBitWidth-1:0] window,
  output logic [1:0]                                     centerSymbol,
  output logic                                           windowValid,
  output logic [rowBitWidth-1:0]                         centerRow,
  output logic [colBitWidth-1:0]                         centerCol,
  output logic                                           done
);

  localparam int N  = 5;
  localparam int AW = (lineDepth > 1) ? $clog2(lineDepth) : 1;
  localparam int LW = pixelBitWidth + 2;

  cfa_state_t             state;
  logic [rowBitWidth-1:0] row, row_max_q;
  logic [colBitWidth-1:0] col, col_max_q, col_next;
  logic                   accept, col_wrap, last_pix;

  logic [LW-1:0]          lb_din [4];
  logic [LW-1:0]          lb_q   [4];
  logic [AW-1:0]          lb_wr_addr, lb_rd_addr;

  logic [pixelBitWidth-1:0] win     [N][N];
  logic [pixelBitWidth-1:0] new_col [N];
  logic [1:0]               sym_pipe [3];
  logic                     unused_sym;

  // start always wins over a coincident pixel
  assign accept   = (state == ST_RUN) && pixelValid && !start;
  assign col_wrap = (col == col_max_q);
  assign last_pix = col_wrap && (row == row_max_q);
  assign col_next = col_wrap ? '0 : col + colBitWidth'(1);

  // Writes land at the current column; reads fetch the column of the next
  // pixel, so each registered line-buffer output is already aligned with the
  // pixel that arrives next, independent of idle gaps in pixelValid.
  assign lb_wr_addr = AW'(col);
  assign lb_rd_addr = AW'(col_next);

  assign lb_din[0] = {bayerSymbolIn, pixelIn};
  assign lb_din[1] = lb_q[0];
  assign lb_din[2] = lb_q[1];
  assign lb_din[3] = lb_q[2];

  for (genvar k = 0; k < 4; k++) begin : g_lb
    cfa_line_buffer #(
      .depth     (lineDepth),
      .width     (LW),
      .addrWidth (AW)
    ) u_lb (
      .clk     (clk),
      .en      (accept),
      .wr_addr (lb_wr_addr),
      .rd_addr (lb_rd_addr),
      .din     (lb_din[k]),
      .dout    (lb_q[k])
    );
  end

  // the oldest line's symbol has no consumer
  assign unused_sym = ^lb_q[3][LW-1 -: 2];

  // new column, oldest line first
  always_comb begin
    new_col[0] = lb_q[3][pixelBitWidth-1:0];
    new_col[1] = lb_q[2][pixelBitWidth-1:0];
    new_col[2] = lb_q[1][pixelBitWidth-1:0];
    new_col[3] = lb_q[0][pixelBitWidth-1:0];
    new_col[4] = pixelIn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          win[r][c] <= '0;
        end
      end
      for (int c = 0; c < 3; c++) begin
        sym_pipe[c] <= BAYER_R;
      end
    end else if (accept) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][N-1] <= new_col[r];
      end
      // only the centre line's symbols matter; tap (2,2) is two shifts old
      sym_pipe[0] <= sym_pipe[1];
      sym_pipe[1] <= sym_pipe[2];
      sym_pipe[2] <= lb_q[1][LW-1 -: 2];
    end
  end

  always_comb begin
    window = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        window[(r*N+c)*pixelBitWidth +: pixelBitWidth] = win[r][c];
      end
    end
  end

  assign centerSymbol = sym_pipe[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ready       <= 1'b1;
      done        <= 1'b0;
      windowValid <= 1'b0;
      row         <= '0;
      col         <= '0;
      row_max_q   <= '0;
      col_max_q   <= '0;
      centerRow   <= '0;
      centerCol   <= '0;
    end else begin
      windowValid <= 1'b0;
      done        <= 1'b0;
      if (start) begin
        state     <= ST_RUN;
        ready     <= 1'b0;
        row       <= '0;
        col       <= '0;
        row_max_q <= rowMax;
        col_max_q <= colMax;
      end else begin
        case (state)
          ST_IDLE: begin
            ready <= 1'b1;
          end
          ST_RUN: begin
            if (accept) begin
              if ((row >= rowBitWidth'(4)) && (col >= colBitWidth'(4))) begin
                windowValid <= 1'b1;
                centerRow   <= row - rowBitWidth'(2);
                centerCol   <= col - colBitWidth'(2);
              end
              if (last_pix) begin
                state <= ST_DONE;
                done  <= 1'b1;
                row   <= '0;
                col   <= '0;
              end else if (col_wrap) begin
                col <= '0;
                row <= row + rowBitWidth'(1);
              end else begin
                col <= col + colBitWidth'(1);
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
          default: begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
